// File: rtl/sdma_chan_arbiter.sv
// sdma_chan_arbiter
//   Shares fabric SDMA channel 0 among NUM_REQ requesters. Requesters are
//   granted round-robin. The arbiter then runs the Req -> Active -> Done
//   handshake with the macro and reports each completion. A watchdog aborts
//   a transfer that never sees Done.
//
// Ports
//   WB_CLK, WB_RST_n    clock and synchronous active-low reset
//   enable_i            0 blocks new grants; an in-flight transfer still finishes
//   req_i[NUM_REQ]      level requests, sampled only while idle
//   grant_o[NUM_REQ]    one-hot grant, held from REQ through DONE/ABORT
//   done_o[NUM_REQ]     1-cycle completion pulse for the granted requester
//   SDMA_Req_o          request to channel 0 (high only in REQ)
//   SDMA_Active_i       channel active, from the macro
//   SDMA_Done_i         channel done pulse, from the macro
//   dma_intr_o          1-cycle pulse on every completion or abort
//   busy_o              state != IDLE
//   timeout_o           sticky watchdog flag; timeout_clr_i clears it
//   timeout_idx_o       requester that was aborted last
module sdma_chan_arbiter #(
  parameter int                   NUM_REQ     = 4,
  parameter int                   TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic               WB_CLK,
  input  logic               WB_RST_n,
  input  logic               enable_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               SDMA_Req_o,
  input  logic               SDMA_Active_i,
  input  logic               SDMA_Done_i,
  output logic               dma_intr_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [2:0]         timeout_idx_o,
  input  logic               timeout_clr_i
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ABORT  = 3'd4;

  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_CYC - 1'b1;
  localparam logic                 WD_EN  = (TIMEOUT_CYC != '0);

  logic [2:0]           state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [2:0]           ptr_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [NUM_REQ-1:0]   grant_q, done_q;
  logic                 sreq_q, intr_q, busy_q, to_q;
  logic [2:0]           to_idx_q;

  // Widened copy of req_i so a 3-bit index is always in range.
  logic [7:0] req_ext;
  logic [2:0] pick;
  logic       hit;
  logic       expire;
  logic [2:0] ptr_inc;
  logic [7:0] oh_sel;

  assign req_ext = 8'(req_i);
  assign expire  = WD_EN && (cnt_q == TO_LIM);
  assign ptr_inc = (sel_q == 3'(NUM_REQ - 1)) ? 3'd0 : sel_q + 3'd1;
  assign oh_sel  = 8'd1 << sel_d;

  // Round-robin search starting at ptr_q. The loop runs from the farthest
  // offset down to the nearest, so the nearest set request is written last
  // and therefore wins.
  always_comb begin
    logic [3:0] idx;
    pick = '0;
    hit  = 1'b0;
    idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr_q} + 4'(i);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (req_ext[idx[2:0]]) begin
        pick = idx[2:0];
        hit  = 1'b1;
      end
    end
  end

  // Done takes priority over watchdog expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: if (enable_i && hit) begin
        state_d = ST_REQ;
        sel_d   = pick;
      end
      ST_REQ: begin
        if (SDMA_Done_i)        state_d = ST_DONE;
        else if (expire)        state_d = ST_ABORT;
        else if (SDMA_Active_i) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (SDMA_Done_i)        state_d = ST_DONE;
        else if (expire)        state_d = ST_ABORT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state. This keeps every port a
  // flop output while showing the new state in the same cycle it is entered.
  always_ff @(posedge WB_CLK) begin
    if (!WB_RST_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      sreq_q   <= 1'b0;
      intr_q   <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      to_idx_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      // The counter rests at 0 while idle, so it always starts at 0 in REQ.
      if (state_q == ST_IDLE)
        cnt_q <= '0;
      else if (state_q == ST_REQ || state_q == ST_ACTIVE)
        cnt_q <= cnt_q + 1'b1;
      if (state_d == ST_DONE || state_d == ST_ABORT)
        ptr_q <= ptr_inc;
      grant_q <= (state_d != ST_IDLE) ? oh_sel[NUM_REQ-1:0] : '0;
      done_q  <= (state_d == ST_DONE) ? oh_sel[NUM_REQ-1:0] : '0;
      sreq_q  <= (state_d == ST_REQ);
      intr_q  <= (state_d == ST_DONE) || (state_d == ST_ABORT);
      busy_q  <= (state_d != ST_IDLE);
      // If set and clear arrive together, set wins.
      if (state_d == ST_ABORT) begin
        to_q     <= 1'b1;
        to_idx_q <= sel_q;
      end else if (timeout_clr_i) begin
        to_q     <= 1'b0;
      end
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign SDMA_Req_o    = sreq_q;
  assign dma_intr_o    = intr_q;
  assign busy_o        = busy_q;
  assign timeout_o     = to_q;
  assign timeout_idx_o = to_idx_q;

endmodule

// File: tb/tb_sdma_chan_arbiter.sv
module tb_sdma_chan_arbiter;
  localparam int NR = 4;
  localparam int TO = 8;

  logic          WB_CLK = 1'b0;
  logic          WB_RST_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [NR-1:0] req_i = '0;
  logic [NR-1:0] grant_o, done_o;
  logic          SDMA_Req_o, SDMA_Active_i = 1'b0, SDMA_Done_i = 1'b0;
  logic          dma_intr_o, busy_o, timeout_o, timeout_clr_i = 1'b0;
  logic [2:0]    timeout_idx_o;

  int checks = 0;
  int errors = 0;

  sdma_chan_arbiter #(.NUM_REQ(NR), .TIMEOUT_W(16), .TIMEOUT_CYC(16'd8)) dut (
    .WB_CLK(WB_CLK), .WB_RST_n(WB_RST_n), .enable_i(enable_i), .req_i(req_i),
    .grant_o(grant_o), .done_o(done_o), .SDMA_Req_o(SDMA_Req_o),
    .SDMA_Active_i(SDMA_Active_i), .SDMA_Done_i(SDMA_Done_i),
    .dma_intr_o(dma_intr_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .timeout_idx_o(timeout_idx_o), .timeout_clr_i(timeout_clr_i));

  always #5 WB_CLK = ~WB_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the channel, how long it has
  // owned it, whether Req is still up, and how the transfer is ending.
  int  m_owner = -1;   // -1 = nobody granted
  int  m_age   = 0;    // cycles since SDMA_Req rose
  bit  m_reqhi = 0;
  int  m_end   = 0;    // 0 running/idle, 1 completing, 2 aborting
  int  m_ptr   = 0;
  bit  m_tmo   = 0;
  int  m_tidx  = 0;
  bit  m_started = 0;

  always @(posedge WB_CLK) begin
    m_started = 1;
    if (!WB_RST_n) begin
      m_owner = -1; m_age = 0; m_reqhi = 0; m_end = 0;
      m_ptr = 0; m_tmo = 0; m_tidx = 0;
    end else begin
      if (timeout_clr_i) m_tmo = 0;
      if (m_end != 0) begin
        m_end = 0; m_owner = -1;
      end else if (m_owner < 0) begin
        if (enable_i && req_i != 0) begin
          for (int k = 0; k < NR; k++) begin
            int c;
            c = (m_ptr + k) % NR;
            if (req_i[c]) begin m_owner = c; break; end
          end
          m_age = 0; m_reqhi = 1;
        end
      end else if (SDMA_Done_i) begin
        m_end = 1; m_reqhi = 0; m_ptr = (m_owner + 1) % NR;
      end else if (m_age == TO - 1) begin
        m_end = 2; m_reqhi = 0; m_ptr = (m_owner + 1) % NR;
        m_tmo = 1; m_tidx = m_owner;
      end else begin
        if (SDMA_Active_i) m_reqhi = 0;
        m_age++;
      end
    end
  end

  // Compare against the model on every falling edge.
  always @(negedge WB_CLK) begin
    if (m_started) begin
      logic [NR-1:0] eg;
      eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
      chk("cyc_grant", 32'(grant_o), 32'(eg));
      chk("cyc_done",  32'(done_o), (m_end == 1) ? 32'(eg) : 32'd0);
      chk("cyc_sreq",  32'(SDMA_Req_o), 32'(m_reqhi));
      chk("cyc_intr",  32'(dma_intr_o), 32'(m_end != 0));
      chk("cyc_busy",  32'(busy_o), 32'(m_owner >= 0));
      chk("cyc_tmo",   32'(timeout_o), 32'(m_tmo));
      chk("cyc_tidx",  32'(timeout_idx_o), 32'(m_tidx));
    end
  end

  task automatic tick();
    @(posedge WB_CLK); #1;
  endtask

  task automatic do_reset();
    WB_RST_n = 0; SDMA_Active_i = 0; SDMA_Done_i = 0; timeout_clr_i = 0;
    tick(); tick();
    WB_RST_n = 1;
  endtask

  task automatic wait_sreq(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (SDMA_Req_o) begin ok = 1; break; end
    end
    chk("wait_sreq", 32'(ok), 32'd1);
  endtask

  function automatic int gidx(input logic [NR-1:0] g);
    gidx = -1;
    for (int i = 0; i < NR; i++) if (g[i]) gidx = i;
  endfunction

  // One full transfer: Active for a cycle, then Done. Returns the grantee.
  task automatic do_xfer(output int g);
    bit ok;
    wait_sreq(ok);
    g = gidx(grant_o);
    SDMA_Active_i = 1; tick();
    SDMA_Active_i = 0; SDMA_Done_i = 1; tick();
    SDMA_Done_i = 0;
    chk("xfer_done", 32'(done_o), 32'(grant_o));
    chk("xfer_intr", 32'(dma_intr_o), 32'd1);
    tick();
  endtask

  initial begin
    bit ok;
    int g;
    int exp_rr[5];
    int exp_ab[3];
    exp_rr = '{0, 1, 2, 3, 0};
    exp_ab = '{1, 3, 1};

    // Single requester
    do_reset();
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    enable_i = 1; req_i = 4'b0100;
    tick();
    chk("single_grant", 32'(grant_o), 32'h4);
    chk("single_sreq", 32'(SDMA_Req_o), 32'd1);
    req_i = 4'b0000;
    tick(); tick();
    SDMA_Active_i = 1; tick(); SDMA_Active_i = 0;
    chk("single_sreq_low", 32'(SDMA_Req_o), 32'd0);
    chk("single_hold", 32'(grant_o), 32'h4);
    tick();
    SDMA_Done_i = 1; tick(); SDMA_Done_i = 0;
    chk("single_done", 32'(done_o), 32'h4);
    chk("single_intr", 32'(dma_intr_o), 32'd1);
    tick();
    chk("single_done_off", 32'(done_o), 32'd0);
    chk("single_idle", 32'(busy_o), 32'd0);

    // Round robin, all requesting
    do_reset();
    enable_i = 1; req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_xfer(g);
      chk("rr_1111", 32'(g), 32'(exp_rr[i]));
    end
    do_reset();
    req_i = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      do_xfer(g);
      chk("rr_1010", 32'(g), 32'(exp_ab[i]));
    end

    // Fast Done while still in REQ
    do_reset();
    req_i = 4'b0001;
    wait_sreq(ok);
    SDMA_Active_i = 1; SDMA_Done_i = 1; tick();
    SDMA_Active_i = 0; SDMA_Done_i = 0;
    chk("fast_done", 32'(done_o), 32'h1);
    tick();
    chk("fast_done_once", 32'(done_o), 32'd0);

    // Watchdog abort on requester 2
    do_reset();
    req_i = 4'b0100;
    wait_sreq(ok);
    req_i = 4'b1111;
    SDMA_Active_i = 1;
    repeat (7) tick();
    chk("wd_not_yet", 32'(dma_intr_o), 32'd0);
    tick();
    SDMA_Active_i = 0;
    chk("wd_intr", 32'(dma_intr_o), 32'd1);
    chk("wd_tmo", 32'(timeout_o), 32'd1);
    chk("wd_idx", 32'(timeout_idx_o), 32'd2);
    chk("wd_nodone", 32'(done_o), 32'd0);
    tick();
    do_xfer(g);
    chk("wd_next", 32'(g), 32'd3);
    chk("wd_sticky", 32'(timeout_o), 32'd1);
    timeout_clr_i = 1; tick(); timeout_clr_i = 0;
    chk("wd_clr", 32'(timeout_o), 32'd0);

    // Done in the same cycle the watchdog would expire
    do_reset();
    req_i = 4'b0001;
    wait_sreq(ok);
    SDMA_Active_i = 1;
    repeat (7) tick();
    SDMA_Active_i = 0; SDMA_Done_i = 1; tick(); SDMA_Done_i = 0;
    chk("tie_done", 32'(done_o), 32'h1);
    chk("tie_tmo", 32'(timeout_o), 32'd0);

    // enable dropped mid-transfer
    do_reset();
    req_i = 4'b1111;
    wait_sreq(ok);
    SDMA_Active_i = 1; tick(); SDMA_Active_i = 0;
    enable_i = 0; tick();
    SDMA_Done_i = 1; tick(); SDMA_Done_i = 0;
    chk("en_done", 32'(done_o), 32'h1);
    repeat (5) tick();
    chk("en_blocked", 32'(grant_o), 32'd0);
    enable_i = 1; tick();
    chk("en_resume", 32'(grant_o), 32'h2);

    // Reset in ACTIVE
    wait_sreq(ok);
    SDMA_Active_i = 1; tick();
    WB_RST_n = 0; tick();
    chk("rst_act_grant", 32'(grant_o), 32'd0);
    chk("rst_act_done", 32'(done_o), 32'd0);
    chk("rst_act_busy", 32'(busy_o), 32'd0);
    WB_RST_n = 1; SDMA_Active_i = 0; req_i = 4'b1111;
    tick();
    chk("rst_act_ptr", 32'(grant_o), 32'h1);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      WB_RST_n      = ($urandom_range(0, 199) != 0);
      enable_i      = ($urandom_range(0, 9) != 0);
      req_i         = NR'($urandom);
      SDMA_Active_i = ($urandom_range(0, 3) == 0);
      SDMA_Done_i   = ($urandom_range(0, 9) == 0);
      timeout_clr_i = ($urandom_range(0, 15) == 0);
    end
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
